// File: rtl/uart_packet_parser.sv
// Frames UART bytes into {opcode, reserved, len_lsb, len_msb, payload} packets and issues ALU
// commands or echoes the payload. Define PARSER_TIMEOUT_EN to enable the inter-byte timeout.
module uart_packet_parser #(
  parameter int DATA_W         = 32,
  parameter int MAX_OPERANDS   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rx_data_i,
  input  logic                              rx_valid_i,
  output logic [7:0]                        echo_data_o,
  output logic                              echo_valid_o,
  output logic                              cmd_valid_o,
  input  logic                              cmd_ready_i,
  output logic [7:0]                        cmd_opcode_o,
  output logic [$clog2(MAX_OPERANDS+1)-1:0] cmd_count_o,
  output logic [MAX_OPERANDS*DATA_W-1:0]    cmd_operands_o,
  output logic                              err_o,
  output logic [1:0]                        err_code_o,
  output logic                              busy_o
);

  localparam int          CNT_W = $clog2(MAX_OPERANDS+1);
  localparam int          B     = DATA_W/8;
  localparam int          BI_W  = (B > 1) ? $clog2(B) : 1;
  localparam logic [31:0] B_U   = 32'(B);
  localparam logic [31:0] MAX_U = 32'(MAX_OPERANDS);

  // Opcode encodings shared with the ALU side.
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;
  localparam logic [7:0] OP_ECHO = 8'h04;

  localparam logic [1:0] ERR_OPCODE  = 2'd0;
  localparam logic [1:0] ERR_LENGTH  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_OPCODE, S_RESERVED, S_LSB, S_MSB, S_PAYLOAD, S_ECHO, S_DRAIN, S_ISSUE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        opcode_q;
  logic [7:0]        lsb_q;
  logic [15:0]       plen_q;
  logic [15:0]       cnt_q;
  logic [CNT_W-1:0]  opnd_idx_q;
  logic [BI_W-1:0]   byte_idx_q;

  logic [15:0]       len_full;
  logic [15:0]       plen;
  logic [31:0]       p32;
  logic              last_byte;
  logic              err_d;
  logic [1:0]        err_code_d;
  logic              echo_d;
  logic              to_hit;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_ADD) || (b == OP_MUL) || (b == OP_DIV) || (b == OP_ECHO);
  endfunction

  assign len_full  = {rx_data_i, lsb_q};
  assign plen      = len_full - 16'd4;
  assign p32       = {16'd0, plen};
  assign last_byte = (cnt_q == plen_q - 16'd1);

`ifdef PARSER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timed;

  // ISSUE and OPCODE are deliberately excluded: an unconsumed command never expires.
  assign timed  = (state_q == S_RESERVED) || (state_q == S_LSB) || (state_q == S_MSB) ||
                  (state_q == S_PAYLOAD) || (state_q == S_ECHO) || (state_q == S_DRAIN);
  assign to_hit = timed && !rx_valid_i && (to_cnt_q == TO_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              to_cnt_q <= '0;
    else if (rx_valid_i || !timed || to_hit) to_cnt_q <= '0;
    else                                  to_cnt_q <= to_cnt_q + TO_W'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    err_code_d = err_code_o;
    echo_d     = 1'b0;
    case (state_q)
      S_OPCODE: if (rx_valid_i) begin
        if (is_opcode(rx_data_i)) begin
          state_d = S_RESERVED;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_OPCODE;
        end
      end
      S_RESERVED: if (rx_valid_i) state_d = S_LSB;
      S_LSB:      if (rx_valid_i) state_d = S_MSB;
      S_MSB: if (rx_valid_i) begin
        if (len_full < 16'd4) begin
          err_d      = 1'b1;
          err_code_d = ERR_LENGTH;
          state_d    = S_OPCODE;
        end else if (opcode_q == OP_ECHO) begin
          state_d = (plen == 16'd0) ? S_OPCODE : S_ECHO;
        end else if (plen == 16'd0) begin
          err_d      = 1'b1;
          err_code_d = ERR_LENGTH;
          state_d    = S_OPCODE;
        end else if (((p32 % B_U) != 32'd0) || ((p32 / B_U) > MAX_U)) begin
          err_d      = 1'b1;
          err_code_d = ERR_LENGTH;
          state_d    = S_DRAIN;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (rx_valid_i && last_byte) state_d = S_ISSUE;
      S_ECHO: if (rx_valid_i) begin
        echo_d = 1'b1;
        if (last_byte) state_d = S_OPCODE;
      end
      S_DRAIN: if (rx_valid_i && last_byte) state_d = S_OPCODE;
      S_ISSUE: begin
        // The stray byte is reported even when the handshake completes on the same cycle.
        if (rx_valid_i) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (cmd_valid_o && cmd_ready_i) state_d = S_OPCODE;
      end
      default: state_d = S_OPCODE;
    endcase
    if (to_hit) begin
      state_d    = S_OPCODE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_OPCODE;
      opcode_q       <= '0;
      lsb_q          <= '0;
      plen_q         <= '0;
      cnt_q          <= '0;
      opnd_idx_q     <= '0;
      byte_idx_q     <= '0;
      echo_data_o    <= '0;
      echo_valid_o   <= 1'b0;
      cmd_valid_o    <= 1'b0;
      cmd_opcode_o   <= '0;
      cmd_count_o    <= '0;
      cmd_operands_o <= '0;
      err_o          <= 1'b0;
      err_code_o     <= '0;
      busy_o         <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_o        <= err_d;
      err_code_o   <= err_code_d;
      echo_valid_o <= echo_d;
      busy_o       <= (state_d != S_OPCODE);
      cmd_valid_o  <= (state_d == S_ISSUE);
      if (echo_d) echo_data_o <= rx_data_i;
      if (rx_valid_i) begin
        case (state_q)
          S_OPCODE: if (is_opcode(rx_data_i)) begin
            opcode_q       <= rx_data_i;
            cmd_operands_o <= '0;
            cmd_count_o    <= '0;
          end
          S_LSB: lsb_q <= rx_data_i;
          S_MSB: begin
            plen_q     <= plen;
            cnt_q      <= '0;
            opnd_idx_q <= '0;
            byte_idx_q <= '0;
          end
          S_PAYLOAD: begin
            cnt_q <= cnt_q + 16'd1;
            for (int j = 0; j < MAX_OPERANDS; j++) begin
              for (int k = 0; k < B; k++) begin
                if (opnd_idx_q == CNT_W'(j) && byte_idx_q == BI_W'(k))
                  cmd_operands_o[j*DATA_W + k*8 +: 8] <= rx_data_i;
              end
            end
            if (byte_idx_q == BI_W'(B-1)) begin
              byte_idx_q <= '0;
              opnd_idx_q <= opnd_idx_q + CNT_W'(1);
            end else begin
              byte_idx_q <= byte_idx_q + BI_W'(1);
            end
            // The final byte always completes an operand, so the index is P/B-1 here.
            if (last_byte) begin
              cmd_count_o  <= opnd_idx_q + CNT_W'(1);
              cmd_opcode_o <= opcode_q;
            end
          end
          S_ECHO, S_DRAIN: cnt_q <= cnt_q + 16'd1;
          default: ;
        endcase
      end
      if (to_hit) cmd_operands_o <= '0;
    end
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: directed packets push expected echo/err/cmd events,
// a negedge monitor pops and compares them, including their arrival cycle.
module tb_uart_packet_parser;
  localparam int DATA_W = 32;
  localparam int MAX_OPERANDS = 4;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;
  localparam logic [7:0] OP_ECHO = 8'h04;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data_i;
  logic         rx_valid_i;
  logic [7:0]   echo_data_o;
  logic         echo_valid_o;
  logic         cmd_valid_o;
  logic         cmd_ready_i;
  logic [7:0]   cmd_opcode_o;
  logic [2:0]   cmd_count_o;
  logic [127:0] cmd_operands_o;
  logic         err_o;
  logic [1:0]   err_code_o;
  logic         busy_o;

  uart_packet_parser #(.DATA_W(DATA_W), .MAX_OPERANDS(MAX_OPERANDS), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .echo_data_o(echo_data_o), .echo_valid_o(echo_valid_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .cmd_opcode_o(cmd_opcode_o), .cmd_count_o(cmd_count_o),
    .cmd_operands_o(cmd_operands_o), .err_o(err_o), .err_code_o(err_code_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int c; } ev_t;
  typedef struct { logic [7:0] op; logic [2:0] cnt; logic [127:0] ops; int c; } cmd_t;

  ev_t  echo_q[$];
  ev_t  err_q[$];
  cmd_t cmd_q[$];
  int   errors = 0;
  int   checks = 0;
  int   dcyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  ev_t  mev;
  cmd_t mce;
  logic cmd_seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cmd_seen = 1'b0;
    end else begin
      if (echo_valid_o) begin
        if (echo_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL echo_unexpected: got %0h expected none", echo_data_o);
        end else begin
          mev = echo_q.pop_front();
          chk("echo_data", 128'(echo_data_o), 128'(mev.d));
          chk("echo_cycle", 128'(cyc), 128'(mev.c));
        end
      end
      if (err_o) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected: got code %0d expected none", err_code_o);
        end else begin
          mev = err_q.pop_front();
          chk("err_code", 128'(err_code_o), 128'(mev.d));
          chk("err_cycle", 128'(cyc), 128'(mev.c));
        end
      end
      if (cmd_valid_o) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: got opcode %0h expected none", cmd_opcode_o);
        end else begin
          mce = cmd_q[0];
          if (!cmd_seen) chk("cmd_cycle", 128'(cyc), 128'(mce.c));
          chk("cmd_opcode", 128'(cmd_opcode_o), 128'(mce.op));
          chk("cmd_count", 128'(cmd_count_o), 128'(mce.cnt));
          chk("cmd_operands", cmd_operands_o, mce.ops);
          if (cmd_ready_i) void'(cmd_q.pop_front());
        end
      end
      cmd_seen = cmd_valid_o && !cmd_ready_i;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    dcyc       = cyc;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send(op); send(8'h00); send(len[7:0]); send(len[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic exp_echo(input logic [7:0] b);
    echo_q.push_back('{b, dcyc + 1});
  endtask

  task automatic exp_err(input logic [7:0] code, input int lat);
    err_q.push_back('{code, dcyc + lat});
  endtask

  task automatic exp_cmd(input logic [7:0] op, input logic [2:0] cnt, input logic [127:0] ops);
    cmd_q.push_back('{op, cnt, ops, dcyc + 1});
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!cmd_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_valid_wait", 128'(cmd_valid_o), 128'(1));
  endtask

  task automatic accept(input int hold);
    idle();
    wait_cmd();
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    cmd_ready_i = 1'b1;
    @(posedge clk); #1;
    cmd_ready_i = 1'b0;
    chk("cmd_valid_drop", 128'(cmd_valid_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; cmd_ready_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_cmd_valid", 128'(cmd_valid_o), 128'(0));
    chk("rst_err_code", 128'(err_code_o), 128'(0));
    chk("rst_operands", cmd_operands_o, 128'(0));
    rst = 1'b0;

    // ADD, two operands, held for 5 cycles before ready
    send_hdr(OP_ADD, 16'h000C); send_word(32'h1); send_word(32'h2);
    exp_cmd(OP_ADD, 3'd2, {32'h0, 32'h0, 32'h2, 32'h1});
    accept(5);

    // ECHO three bytes, then ADD back-to-back
    send_hdr(OP_ECHO, 16'h0007);
    send(8'h41); exp_echo(8'h41);
    send(8'h42); exp_echo(8'h42);
    send(8'h43); exp_echo(8'h43);
    send_hdr(OP_ADD, 16'h0008); send_word(32'h12345678);
    exp_cmd(OP_ADD, 3'd1, {96'h0, 32'h12345678});
    accept(0);

    // MUL with P=3: length error, drain, then a good MUL
    send_hdr(OP_MUL, 16'h0007); exp_err(8'd1, 1);
    send(8'hAA); send(8'hBB); send(8'hCC);
    send_hdr(OP_MUL, 16'h000C); send_word(32'h3); send_word(32'h5);
    exp_cmd(OP_MUL, 3'd2, {64'h0, 32'h5, 32'h3});
    accept(1);

    // Bad opcode, then DIV with the maximum operand count
    send(8'h55); exp_err(8'd0, 1);
    idle();
    chk("busy_after_bad_op", 128'(busy_o), 128'(0));
    send_hdr(OP_DIV, 16'h0014);
    send_word(32'hDEADBEEF); send_word(32'h04030201); send_word(32'hFFFFFFFF); send_word(32'h80000000);
    exp_cmd(OP_DIV, 3'd4, {32'h80000000, 32'hFFFFFFFF, 32'h04030201, 32'hDEADBEEF});
    accept(2);

    // Too many operands (drain 20), P=0, L<4, empty ECHO, then a good ADD
    send_hdr(OP_ADD, 16'h0018); exp_err(8'd1, 1);
    for (int i = 0; i < 20; i++) send(8'(i));
    send_hdr(OP_ADD, 16'h0004); exp_err(8'd1, 1);
    send_hdr(OP_ADD, 16'h0002); exp_err(8'd1, 1);
    send_hdr(OP_ECHO, 16'h0004);
    send_hdr(OP_ADD, 16'h0008); send_word(32'h0BADF00D);
    exp_cmd(OP_ADD, 3'd1, {96'h0, 32'h0BADF00D});
    accept(0);

    // Overrun during ISSUE and on the handshake cycle, then an immediate opcode
    send_hdr(OP_ADD, 16'h0008); send_word(32'h7);
    exp_cmd(OP_ADD, 3'd1, {96'h0, 32'h7});
    idle();
    wait_cmd();
    send(8'hAA); exp_err(8'd2, 1);
    idle(); idle();
    @(posedge clk); #1;
    cmd_ready_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'hBB; dcyc = cyc;
    exp_err(8'd2, 1);
    send(OP_ADD);
    cmd_ready_i = 1'b0;
    chk("cmd_drop_after_hs", 128'(cmd_valid_o), 128'(0));
    send(8'h00); send(8'h08); send(8'h00); send_word(32'h9);
    exp_cmd(OP_ADD, 3'd1, {96'h0, 32'h9});
    accept(0);

    // Asynchronous reset in the middle of PAYLOAD
    send_hdr(OP_ADD, 16'h000C); send(8'h01); send(8'h02);
    chk("busy_in_payload", 128'(busy_o), 128'(1));
    @(posedge clk); #3;
    rst = 1'b1; rx_valid_i = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy_o), 128'(0));
    chk("midrst_err_code", 128'(err_code_o), 128'(0));
    chk("midrst_cmd_count", 128'(cmd_count_o), 128'(0));
    chk("midrst_operands", cmd_operands_o, 128'(0));
    chk("midrst_opcode", 128'(cmd_opcode_o), 128'(0));
    #10;
    rst = 1'b0;
    send_hdr(OP_ADD, 16'h0008); send_word(32'h2A);
    exp_cmd(OP_ADD, 3'd1, {96'h0, 32'h2A});
    accept(0);

    // Stall after the LSB byte
    send(OP_ADD); send(8'h00); send(8'h08);
`ifdef PARSER_TIMEOUT_EN
    exp_err(8'd3, 17);
    idle();
    repeat (30) @(posedge clk); #1;
    chk("busy_after_timeout", 128'(busy_o), 128'(0));
`else
    idle();
    repeat (40) @(posedge clk); #1;
    chk("busy_waiting", 128'(busy_o), 128'(1));
    rst = 1'b1;
    #3;
    rst = 1'b0;
`endif
    send_hdr(OP_ECHO, 16'h0005);
    send(8'h5A); exp_echo(8'h5A);
    idle();
    repeat (3) @(posedge clk); #1;

    chk("echo_q_empty", 128'(echo_q.size()), 128'(0));
    chk("err_q_empty", 128'(err_q.size()), 128'(0));
    chk("cmd_q_empty", 128'(cmd_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
